// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: state encoding and default word width.
package bit_serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a shift enable, gapless back-to-back
// reload on the last bit, and a one-cycle done pulse per completed frame.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no frame in flight; sout/sout_valid low; en ignored; ready high
// SHIFT | sout carries frame bit number bit_cnt; advances when en is high
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   input  logic             en,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic             last_bit;
   logic             accept;

   // Bit that leaves the word first for the configured shift order.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Word with its head bit consumed; the next head is then in place.
   function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   // A load is taken when idle, or on the edge that retires the last bit.
   always_comb begin
      last_bit = (state == SHIFT) && (bit_cnt == LAST);
      ready    = (state == IDLE) || (last_bit && en);
      accept   = load && ready;
   end

   // Serializer FSM with inline shift register, bit counter and registered outputs.
   // shreg holds the bits still to be sent; sout holds the bit currently on the wire.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (last_bit && en) begin
            done <= 1'b1;
         end
         if (accept) begin
            state      <= SHIFT;
            shreg      <= drop_head(data_in);
            sout       <= head_bit(data_in);
            sout_valid <= 1'b1;
            bit_cnt    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  sout       <= 1'b0;
                  sout_valid <= 1'b0;
               end
               SHIFT: begin
                  if (en) begin
                     if (last_bit) begin
                        state      <= IDLE;
                        shreg      <= '0;
                        bit_cnt    <= '0;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                     end else begin
                        shreg   <= drop_head(shreg);
                        sout    <= head_bit(shreg);
                        bit_cnt <= bit_cnt + CW'(1);
                     end
                  end
               end
               default: begin
                  state      <= IDLE;
                  sout       <= 1'b0;
                  sout_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: a WIDTH=4 MSB-first instance and a WIDTH=8
// LSB-first instance, each checked every cycle against a queue-of-bits model.
module tb_bit_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic [3:0] data_a = '0;
   logic       load_a = 1'b0;
   logic       en_a   = 1'b0;
   logic       ready_a, sout_a, sout_valid_a, done_a;

   logic [7:0] data_b = '0;
   logic       load_b = 1'b0;
   logic       en_b   = 1'b0;
   logic       ready_b, sout_b, sout_valid_b, done_b;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: bits of the frame still owed on sout, head = bit on the wire now.
   bit q_a[$];
   bit q_b[$];
   bit done_exp_a = 1'b0;
   bit done_exp_b = 1'b0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst(rst), .data_in(data_a), .load(load_a), .ready(ready_a),
      .en(en_a), .sout(sout_a), .sout_valid(sout_valid_a), .done(done_a)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .data_in(data_b), .load(load_b), .ready(ready_b),
      .en(en_b), .sout(sout_b), .sout_valid(sout_valid_b), .done(done_b)
   );

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check ready,
   // advance the model across the rising edge, check outputs at the next falling edge.
   task automatic step(input bit la, input logic [3:0] da, input bit ea,
                       input bit lb, input logic [7:0] db, input bit eb);
      bit rdy_a, rdy_b;
      load_a = la; data_a = da; en_a = ea;
      load_b = lb; data_b = db; en_b = eb;
      #1;
      rdy_a = (q_a.size() == 0) || (q_a.size() == 1 && ea);
      rdy_b = (q_b.size() == 0) || (q_b.size() == 1 && eb);
      chk_val("ready_a", ready_a, rdy_a);
      chk_val("ready_b", ready_b, rdy_b);
      @(posedge clk);
      done_exp_a = 1'b0;
      if (q_a.size() > 0 && ea) begin
         void'(q_a.pop_front());
         if (q_a.size() == 0) done_exp_a = 1'b1;
      end
      if (la && rdy_a)
         for (int i = 0; i < 4; i++) q_a.push_back(da[3-i]);
      done_exp_b = 1'b0;
      if (q_b.size() > 0 && eb) begin
         void'(q_b.pop_front());
         if (q_b.size() == 0) done_exp_b = 1'b1;
      end
      if (lb && rdy_b)
         for (int i = 0; i < 8; i++) q_b.push_back(db[i]);
      @(negedge clk);
      chk_val("sout_a",  sout_a,       (q_a.size() > 0) ? q_a[0] : 1'b0);
      chk_val("valid_a", sout_valid_a, q_a.size() > 0);
      chk_val("done_a",  done_a,       done_exp_a);
      chk_val("sout_b",  sout_b,       (q_b.size() > 0) ? q_b[0] : 1'b0);
      chk_val("valid_b", sout_valid_b, q_b.size() > 0);
      chk_val("done_b",  done_b,       done_exp_b);
   endtask

   task automatic step_a(input bit la, input logic [3:0] da, input bit ea);
      step(la, da, ea, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      // Reset: outputs low, ready high, a load during reset is not captured.
      @(negedge clk);
      load_a = 1'b1; data_a = 4'b1111; en_a = 1'b1;
      load_b = 1'b1; data_b = 8'hFF;   en_b = 1'b1;
      #1;
      chk_val("rst_ready_a", ready_a, 1'b1);
      chk_val("rst_ready_b", ready_b, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk_val("rst_sout_a",  sout_a, 1'b0);
      chk_val("rst_valid_a", sout_valid_a, 1'b0);
      chk_val("rst_done_a",  done_a, 1'b0);
      chk_val("rst_valid_b", sout_valid_b, 1'b0);
      load_a = 1'b0; load_b = 1'b0;
      rst = 1'b1;

      // Single frame 1011, then idle.
      step_a(1'b1, 4'b1011, 1'b1);
      repeat (5) step_a(1'b0, 4'b0000, 1'b1);

      // Gapless reload: 1011 then 0110 accepted on the last bit.
      step_a(1'b1, 4'b1011, 1'b1);
      repeat (3) step_a(1'b0, 4'b0000, 1'b1);
      step_a(1'b1, 4'b0110, 1'b1);
      repeat (5) step_a(1'b0, 4'b0000, 1'b1);

      // Stall for two cycles mid-frame.
      step_a(1'b1, 4'b1011, 1'b1);
      step_a(1'b0, 4'b0000, 1'b1);
      step_a(1'b0, 4'b0000, 1'b0);
      step_a(1'b0, 4'b0000, 1'b0);
      repeat (4) step_a(1'b0, 4'b0000, 1'b1);

      // en ignored in IDLE; a stalled last bit does not accept a load.
      repeat (2) step_a(1'b0, 4'b0000, 1'b0);
      step_a(1'b1, 4'b1100, 1'b1);
      repeat (3) step_a(1'b0, 4'b0000, 1'b1);
      step_a(1'b1, 4'b0101, 1'b0);
      step_a(1'b0, 4'b0000, 1'b1);
      step_a(1'b0, 4'b0000, 1'b1);

      // Load held high mid-frame is ignored until the last bit.
      step_a(1'b1, 4'b1011, 1'b1);
      step_a(1'b0, 4'b0000, 1'b1);
      step_a(1'b1, 4'b0001, 1'b1);
      step_a(1'b1, 4'b0001, 1'b1);
      step_a(1'b0, 4'b0000, 1'b1);
      repeat (2) step_a(1'b0, 4'b0000, 1'b1);

      // LSB-first 8-bit word A5 on the second instance.
      step(1'b0, 4'b0000, 1'b0, 1'b1, 8'hA5, 1'b1);
      repeat (9) step(1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b1);

      // Reset mid-frame: outputs drop immediately, no done, clean restart.
      step(1'b1, 4'b1011, 1'b1, 1'b1, 8'h3C, 1'b1);
      step_a(1'b0, 4'b0000, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk_val("mid_rst_sout_a",  sout_a, 1'b0);
      chk_val("mid_rst_valid_a", sout_valid_a, 1'b0);
      chk_val("mid_rst_done_a",  done_a, 1'b0);
      chk_val("mid_rst_valid_b", sout_valid_b, 1'b0);
      q_a.delete();
      q_b.delete();
      @(posedge clk);
      @(negedge clk);
      chk_val("in_rst_done_a", done_a, 1'b0);
      chk_val("in_rst_done_b", done_b, 1'b0);
      rst = 1'b1;
      step_a(1'b0, 4'b0000, 1'b1);
      step_a(1'b1, 4'b1001, 1'b1);
      repeat (5) step_a(1'b0, 4'b0000, 1'b1);

      // Randomized traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 2) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
